// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - write-back arbiter with pending-write scoreboard
// Purpose: picks one of the ALU/LSU/MDU results per cycle (round-robin),
//   registers it onto the register-file write port, and tracks which
//   architectural registers still have a write outstanding.
// Ports:
//   clk, rst_n                    clock, synchronous active-low reset
//   {alu,lsu,mdu}_valid/rd/data   result sources (held until accepted)
//   {alu,lsu,mdu}_ready           combinational grant to each source
//   iss_valid/iss_rd              issued instruction with a destination
//   rs1_addr/rs1_busy             hazard query 1
//   rs2_addr/rs2_busy             hazard query 2
//   busy                          scoreboard vector, bit 0 always 0
//   rd_wen/rd_addr/rd_data        registered register-file write port
module wb_arbiter #(
  parameter int XLEN = 64,
  parameter int AW   = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                alu_valid,
  output logic                alu_ready,
  input  logic [AW-1:0]       alu_rd,
  input  logic [XLEN-1:0]     alu_data,
  input  logic                lsu_valid,
  output logic                lsu_ready,
  input  logic [AW-1:0]       lsu_rd,
  input  logic [XLEN-1:0]     lsu_data,
  input  logic                mdu_valid,
  output logic                mdu_ready,
  input  logic [AW-1:0]       mdu_rd,
  input  logic [XLEN-1:0]     mdu_data,
  input  logic                iss_valid,
  input  logic [AW-1:0]       iss_rd,
  input  logic [AW-1:0]       rs1_addr,
  output logic                rs1_busy,
  input  logic [AW-1:0]       rs2_addr,
  output logic                rs2_busy,
  output logic [(2**AW)-1:0]  busy,
  output logic                rd_wen,
  output logic [AW-1:0]       rd_addr,
  output logic [XLEN-1:0]     rd_data
);

  localparam int NREG = 2**AW;
  localparam logic [1:0] SRC_ALU = 2'd0;
  localparam logic [1:0] SRC_LSU = 2'd1;
  localparam logic [1:0] SRC_MDU = 2'd2;

  logic [1:0]      last_grant;
  logic [2:0]      grant;       // one-hot {mdu, lsu, alu}
  logic [1:0]      grant_src;
  logic            xfer;
  logic [AW-1:0]   sel_rd;
  logic [XLEN-1:0] sel_data;
  logic            sel_wen;
  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;

  // Search starts at the source after the last one granted.
  always_comb begin
    grant = 3'b000;
    case (last_grant)
      SRC_ALU: begin
        if (lsu_valid)      grant = 3'b010;
        else if (mdu_valid) grant = 3'b100;
        else if (alu_valid) grant = 3'b001;
      end
      SRC_LSU: begin
        if (mdu_valid)      grant = 3'b100;
        else if (alu_valid) grant = 3'b001;
        else if (lsu_valid) grant = 3'b010;
      end
      default: begin
        if (alu_valid)      grant = 3'b001;
        else if (lsu_valid) grant = 3'b010;
        else if (mdu_valid) grant = 3'b100;
      end
    endcase
  end

  assign alu_ready = grant[0];
  assign lsu_ready = grant[1];
  assign mdu_ready = grant[2];
  assign xfer      = |grant;

  always_comb begin
    grant_src = last_grant;
    sel_rd    = '0;
    sel_data  = '0;
    if (grant[0]) begin
      grant_src = SRC_ALU;
      sel_rd    = alu_rd;
      sel_data  = alu_data;
    end else if (grant[1]) begin
      grant_src = SRC_LSU;
      sel_rd    = lsu_rd;
      sel_data  = lsu_data;
    end else if (grant[2]) begin
      grant_src = SRC_MDU;
      sel_rd    = mdu_rd;
      sel_data  = mdu_data;
    end
  end

  // Results for x0 are consumed but never written.
  assign sel_wen = xfer && (sel_rd != '0);

  // Set is applied after clear so an issue to the same register wins.
  always_comb begin
    busy_d = busy_q;
    if (sel_wen) busy_d[sel_rd] = 1'b0;
    if (iss_valid && (iss_rd != '0)) busy_d[iss_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_wen     <= 1'b0;
      rd_addr    <= '0;
      rd_data    <= '0;
      last_grant <= SRC_MDU;
      busy_q     <= '0;
    end else begin
      rd_wen <= sel_wen;
      if (sel_wen) begin
        rd_addr <= sel_rd;
        rd_data <= sel_data;
      end
      if (xfer) last_grant <= grant_src;
      busy_q <= busy_d;
    end
  end

  assign busy     = busy_q;
  assign rs1_busy = busy_q[rs1_addr];
  assign rs2_busy = busy_q[rs2_addr];

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - self-checking bench for wb_arbiter
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid, lsu_valid, mdu_valid;
  logic        alu_ready, lsu_ready, mdu_ready;
  logic [4:0]  alu_rd, lsu_rd, mdu_rd;
  logic [63:0] alu_data, lsu_data, mdu_data;
  logic        iss_valid;
  logic [4:0]  iss_rd, rs1_addr, rs2_addr;
  logic        rs1_busy, rs2_busy;
  logic [31:0] busy;
  logic        rd_wen;
  logic [4:0]  rd_addr;
  logic [63:0] rd_data;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  wb_arbiter #(.XLEN(64), .AW(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .mdu_valid(mdu_valid), .mdu_ready(mdu_ready), .mdu_rd(mdu_rd), .mdu_data(mdu_data),
    .iss_valid(iss_valid), .iss_rd(iss_rd),
    .rs1_addr(rs1_addr), .rs1_busy(rs1_busy),
    .rs2_addr(rs2_addr), .rs2_busy(rs2_busy),
    .busy(busy), .rd_wen(rd_wen), .rd_addr(rd_addr), .rd_data(rd_data)
  );

  typedef struct {
    logic [2:0] req;      // {mdu, lsu, alu} valid
    logic [2:0] exp_gnt;  // {mdu, lsu, alu} ready
  } vec_t;

  vec_t        vecs[12];
  logic [63:0] sdata[3];
  logic [2:0]  t3_exp[4];

  // Reference model state for the random phase
  int          m_last;
  logic [31:0] m_busy;
  logic        pv[3];
  logic [4:0]  prd[3];
  logic [63:0] pdat[3];
  logic        exp_wen;
  logic [4:0]  exp_addr;
  logic [63:0] exp_data;
  int          g;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    alu_valid = 0; lsu_valid = 0; mdu_valid = 0; iss_valid = 0;
    alu_rd = 0; lsu_rd = 0; mdu_rd = 0; iss_rd = 0;
    alu_data = 0; lsu_data = 0; mdu_data = 0;
    rs1_addr = 0; rs2_addr = 0;
  endtask

  task automatic do_reset;
    idle_inputs();
    rst_n = 0;
    tick();
    rst_n = 1;
  endtask

  task automatic drive_fixed(input logic [2:0] req);
    alu_valid = req[0]; alu_rd = 5'd1; alu_data = sdata[0];
    lsu_valid = req[1]; lsu_rd = 5'd2; lsu_data = sdata[1];
    mdu_valid = req[2]; mdu_rd = 5'd3; mdu_data = sdata[2];
  endtask

  initial begin
    sdata[0] = 64'h1111_1111_1111_1111;
    sdata[1] = 64'h2222_2222_2222_2222;
    sdata[2] = 64'h3333_3333_3333_3333;
    t3_exp[0] = 3'b001; t3_exp[1] = 3'b010; t3_exp[2] = 3'b100; t3_exp[3] = 3'b001;
    // Unaccepted requests persist into the next row.
    vecs[0]  = '{3'b111, 3'b001};
    vecs[1]  = '{3'b110, 3'b010};
    vecs[2]  = '{3'b101, 3'b100};
    vecs[3]  = '{3'b001, 3'b001};
    vecs[4]  = '{3'b000, 3'b000};
    vecs[5]  = '{3'b101, 3'b100};
    vecs[6]  = '{3'b011, 3'b001};
    vecs[7]  = '{3'b010, 3'b010};
    vecs[8]  = '{3'b111, 3'b100};
    vecs[9]  = '{3'b011, 3'b001};
    vecs[10] = '{3'b010, 3'b010};
    vecs[11] = '{3'b001, 3'b001};

    // T1 reset
    idle_inputs();
    rst_n = 0;
    tick();
    check("t1_rd_wen", rd_wen, 0);
    check("t1_rd_addr", rd_addr, 0);
    check("t1_rd_data", rd_data, 0);
    check("t1_busy", busy, 0);
    check("t1_ready", {mdu_ready, lsu_ready, alu_ready}, 0);
    rst_n = 1;

    // T2 single ALU result
    alu_valid = 1; alu_rd = 5'd5; alu_data = 64'hDEAD_BEEF_CAFE_BABE;
    #1 check("t2_alu_ready", {mdu_ready, lsu_ready, alu_ready}, 3'b001);
    tick();
    alu_valid = 0;
    check("t2_wen", rd_wen, 1);
    check("t2_addr", rd_addr, 5);
    check("t2_data", rd_data, 64'hDEAD_BEEF_CAFE_BABE);
    tick();
    check("t2_wen_off", rd_wen, 0);
    check("t2_addr_hold", rd_addr, 5);

    // T3 rotation with all sources continuously valid
    do_reset();
    drive_fixed(3'b111);
    for (int i = 0; i < 4; i++) begin
      #1 check("t3_grant", {mdu_ready, lsu_ready, alu_ready}, t3_exp[i]);
      tick();
      check("t3_wen", rd_wen, 1);
      check("t3_addr", rd_addr, (t3_exp[i] == 3'b001) ? 1 : (t3_exp[i] == 3'b010) ? 2 : 3);
    end
    idle_inputs();
    tick();

    // T4 scoreboard
    iss_valid = 1; iss_rd = 5'd7;
    tick();
    iss_valid = 0; rs1_addr = 5'd7;
    #1 check("t4_rs1_busy_set", rs1_busy, 1);
    check("t4_busy7", busy[7], 1);
    lsu_valid = 1; lsu_rd = 5'd7; lsu_data = 64'h7777;
    #1 check("t4_lsu_ready", lsu_ready, 1);
    check("t4_no_bypass", rs1_busy, 1);
    tick();
    lsu_valid = 0;
    #1 check("t4_rs1_busy_clr", rs1_busy, 0);
    iss_valid = 1; iss_rd = 5'd7;
    tick();
    lsu_valid = 1; lsu_rd = 5'd7;
    tick();
    iss_valid = 0; lsu_valid = 0;
    #1 check("t4_set_wins", rs1_busy, 1);
    check("t4_set_wins_wen", rd_wen, 1);
    iss_valid = 1; iss_rd = 5'd8; lsu_valid = 1; lsu_rd = 5'd7;
    tick();
    iss_valid = 0; lsu_valid = 0;
    check("t4_diff_rd", busy, 32'h0000_0100);
    lsu_valid = 1; lsu_rd = 5'd8;
    tick();
    lsu_valid = 0;
    check("t4_drain", busy, 0);

    // T5 x0 destination
    mdu_valid = 1; mdu_rd = 5'd0; mdu_data = '1;
    #1 check("t5_mdu_ready", mdu_ready, 1);
    tick();
    mdu_valid = 0;
    check("t5_no_wen", rd_wen, 0);
    iss_valid = 1; iss_rd = 5'd0; rs2_addr = 5'd0;
    tick();
    iss_valid = 0;
    check("t5_busy", busy, 0);
    check("t5_rs2_busy", rs2_busy, 0);

    // T6 reset while a result is being accepted
    iss_valid = 1; iss_rd = 5'd9;
    tick();
    iss_valid = 0;
    check("t6_busy9", busy[9], 1);
    alu_valid = 1; alu_rd = 5'd9; alu_data = 64'h9999; rst_n = 0;
    tick();
    rst_n = 1; alu_valid = 0;
    check("t6_no_wen", rd_wen, 0);
    check("t6_busy", busy, 0);
    drive_fixed(3'b111);
    #1 check("t6_alu_first", {mdu_ready, lsu_ready, alu_ready}, 3'b001);
    idle_inputs();

    // Table-driven arbitration vectors from reset
    do_reset();
    for (int i = 0; i < 12; i++) begin
      drive_fixed(vecs[i].req);
      #1 check("tbl_grant", {mdu_ready, lsu_ready, alu_ready}, vecs[i].exp_gnt);
      tick();
      check("tbl_wen", rd_wen, |vecs[i].exp_gnt);
      if (vecs[i].exp_gnt[0])      check("tbl_data", rd_data, sdata[0]);
      else if (vecs[i].exp_gnt[1]) check("tbl_data", rd_data, sdata[1]);
      else if (vecs[i].exp_gnt[2]) check("tbl_data", rd_data, sdata[2]);
    end

    // Randomized run against the reference model
    do_reset();
    m_last = 2;
    m_busy = 0;
    for (int s = 0; s < 3; s++) pv[s] = 0;
    for (int c = 0; c < 400; c++) begin
      for (int s = 0; s < 3; s++) begin
        if (!pv[s] && ($urandom_range(0, 2) != 0)) begin
          pv[s]   = 1;
          prd[s]  = 5'($urandom_range(0, 31));
          pdat[s] = {$urandom(), $urandom()};
        end
      end
      alu_valid = pv[0]; alu_rd = prd[0]; alu_data = pdat[0];
      lsu_valid = pv[1]; lsu_rd = prd[1]; lsu_data = pdat[1];
      mdu_valid = pv[2]; mdu_rd = prd[2]; mdu_data = pdat[2];
      iss_valid = 1'($urandom_range(0, 1));
      iss_rd    = 5'($urandom_range(0, 31));
      rs1_addr  = 5'($urandom_range(0, 31));
      rs2_addr  = 5'($urandom_range(0, 31));
      #1;
      g = -1;
      for (int k = 1; k <= 3; k++)
        if (g < 0 && pv[(m_last + k) % 3]) g = (m_last + k) % 3;
      check("rnd_alu_ready", alu_ready, g == 0);
      check("rnd_lsu_ready", lsu_ready, g == 1);
      check("rnd_mdu_ready", mdu_ready, g == 2);
      check("rnd_rs1_busy", rs1_busy, m_busy[rs1_addr]);
      check("rnd_rs2_busy", rs2_busy, m_busy[rs2_addr]);
      exp_wen = 0;
      if (g >= 0) begin
        m_last = g;
        pv[g]  = 0;
        if (prd[g] != 0) begin
          exp_wen  = 1;
          exp_addr = prd[g];
          exp_data = pdat[g];
          m_busy[prd[g]] = 0;
        end
      end
      if (iss_valid && iss_rd != 0) m_busy[iss_rd] = 1;
      tick();
      check("rnd_wen", rd_wen, exp_wen);
      if (exp_wen) begin
        check("rnd_addr", rd_addr, exp_addr);
        check("rnd_data", rd_data, exp_data);
      end
      check("rnd_busy", busy, m_busy);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
